// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the sequential ALU.
// Also holds the predicate that picks out the multi-cycle opcodes.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_XOR  = 4'b0011,
      OP_SLL  = 4'b0100,
      OP_SRL  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_SLT  = 4'b0111,
      OP_MUL  = 4'b1000,
      OP_DIVU = 4'b1001,
      OP_REMU = 4'b1010,
      OP_NOR  = 4'b1100
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   // Opcodes executed by the iterative multiply/divide unit.
   function automatic logic is_iterative(input logic [3:0] code);
      return (code == OP_MUL) || (code == OP_DIVU) || (code == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide/remainder (restoring),
// one step per cycle over WIDTH cycles; done marks the final step's cycle.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [CNT_W-1:0] count_reg;
   logic [3:0]       op_reg;
   // q_reg: multiplier (MUL) or dividend/quotient shift register (DIVU/REMU).
   // d_reg: multiplicand (MUL) or divisor. acc_reg: product or partial remainder.
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] acc_reg;

   logic [WIDTH:0]   shifted;
   logic             rem_ge;
   logic [WIDTH-1:0] rem_diff;
   logic [WIDTH-1:0] div_rem_next;
   logic [WIDTH-1:0] div_q_next;
   logic [WIDTH-1:0] mul_acc_next;
   logic [WIDTH-1:0] mul_q_next;
   logic [WIDTH-1:0] mul_d_next;

   always_comb begin
      shifted      = {acc_reg, q_reg[WIDTH-1]};
      rem_ge       = shifted >= {1'b0, d_reg};
      // True difference is always below 2**WIDTH when rem_ge holds.
      rem_diff     = shifted[WIDTH-1:0] - d_reg;
      div_rem_next = rem_ge ? rem_diff : shifted[WIDTH-1:0];
      div_q_next   = {q_reg[WIDTH-2:0], rem_ge};
      mul_acc_next = acc_reg + (q_reg[0] ? d_reg : '0);
      mul_q_next   = q_reg >> 1;
      mul_d_next   = d_reg << 1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
         op_reg    <= OP_AND;
         q_reg     <= '0;
         d_reg     <= '0;
         acc_reg   <= '0;
      end else if (start) begin
         count_reg <= CNT_W'(WIDTH);
         op_reg    <= op;
         q_reg     <= a;
         d_reg     <= b;
         acc_reg   <= '0;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
         if (op_reg == OP_MUL) begin
            acc_reg <= mul_acc_next;
            q_reg   <= mul_q_next;
            d_reg   <= mul_d_next;
         end else begin
            acc_reg <= div_rem_next;
            q_reg   <= div_q_next;
         end
      end
   end

   // Divide by zero falls out of the restoring loop naturally:
   // every step succeeds (quotient all ones) and A shifts into the remainder.
   assign done = (count_reg == CNT_W'(1));

   always_comb begin
      case (op_reg)
         OP_MUL:  result = mul_acc_next;
         OP_DIVU: result = div_q_next;
         default: result = div_rem_next;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, iterative MUL/DIVU/REMU,
// with a registered result held until the consumer takes it.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_Sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_Out,
   output logic             coutfin,
   output logic             z,
   output logic             ovf
);

   localparam int SH_W = $clog2(WIDTH);
   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   alu_state_e       state_reg;
   alu_state_e       state_next;
   logic [WIDTH-1:0] out_reg;
   logic             cout_reg;
   logic             ovf_reg;

   logic             accept;
   logic             start_iter;
   logic [WIDTH:0]   sum_add;
   logic [WIDTH:0]   sum_sub;
   logic             ovf_add;
   logic             ovf_sub;
   logic [WIDTH-1:0] simple_res;
   logic             simple_cout;
   logic             simple_ovf;
   logic             iter_done;
   logic [WIDTH-1:0] iter_res;

   // Ready passes straight through from out_ready in DONE for back-to-back issue.
   assign in_ready   = !rst && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
   assign accept     = in_valid && in_ready;
   assign start_iter = accept && is_iterative(ALU_Sel);

   always_comb begin
      sum_add = {1'b0, A} + {1'b0, B};
      sum_sub = {1'b0, A} + {1'b0, ~B} + ONE;
      ovf_add = (A[WIDTH-1] == B[WIDTH-1]) && (sum_add[WIDTH-1] != A[WIDTH-1]);
      ovf_sub = (A[WIDTH-1] != B[WIDTH-1]) && (sum_sub[WIDTH-1] != A[WIDTH-1]);
   end

   always_comb begin
      simple_res  = '0;
      simple_cout = 1'b0;
      simple_ovf  = 1'b0;
      case (ALU_Sel)
         OP_AND: simple_res = A & B;
         OP_OR:  simple_res = A | B;
         OP_XOR: simple_res = A ^ B;
         OP_NOR: simple_res = ~(A | B);
         OP_SLL: simple_res = A << B[SH_W-1:0];
         OP_SRL: simple_res = A >> B[SH_W-1:0];
         OP_ADD: begin
            simple_res  = sum_add[WIDTH-1:0];
            simple_cout = sum_add[WIDTH];
            simple_ovf  = ovf_add;
         end
         OP_SUB: begin
            simple_res  = sum_sub[WIDTH-1:0];
            simple_cout = sum_sub[WIDTH];
            simple_ovf  = ovf_sub;
         end
         OP_SLT: begin
            simple_res  = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1] ^ ovf_sub};
            simple_cout = sum_sub[WIDTH];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      if (accept) begin
         state_next = start_iter ? BUSY : DONE;
      end else begin
         case (state_reg)
            IDLE:    state_next = IDLE;
            BUSY:    if (iter_done) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         out_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept && !start_iter) begin
            out_reg  <= simple_res;
            cout_reg <= simple_cout;
            ovf_reg  <= simple_ovf;
         end else if ((state_reg == BUSY) && iter_done) begin
            out_reg  <= iter_res;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
         end
      end
   end

   alu_iter_muldiv #(
      .WIDTH(WIDTH)
   ) u_iter (
      .clk   (clk),
      .rst   (rst),
      .start (start_iter),
      .op    (ALU_Sel),
      .a     (A),
      .b     (B),
      .done  (iter_done),
      .result(iter_res)
   );

   assign out_valid = (state_reg == DONE);
   assign ALU_Out   = out_reg;
   assign coutfin   = cout_reg;
   assign ovf       = ovf_reg;
   assign z         = (out_reg == '0);

endmodule
